// File: rtl/mpu_det_bareiss.sv
// mpu_det_bareiss: sequential determinant engine for n x n signed matrices
// (n = 1..MAX_N). Fraction-free Bareiss elimination with row-swap pivoting
// gives an exact integer result; the reduction to OUT_W bits happens once,
// at the end.
// Build option: define MPU_DET_SAT_EN to saturate the determinant to the
// OUT_W signed range instead of wrapping it.
module mpu_det_bareiss #(
  parameter int MAX_N = 5,
  parameter int W     = 8,
  parameter int OUT_W = 8,
  parameter int ACC_W = 48
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [3:0]               i_size,
  input  logic [MAX_N*MAX_N*W-1:0] i_matrix,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [OUT_W-1:0]         o_result,
  output logic                     o_singular,
  output logic                     o_bad_size
);

  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int PW    = 2 * ACC_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PIVOT, S_SCAN, S_SWAP, S_ELIM, S_FINISH
  } state_t;

  state_t r_state, w_next;

  logic signed [ACC_W-1:0] r_a [MAX_N][MAX_N];
  logic signed [ACC_W-1:0] r_prev;
  logic [IDX_W-1:0]        r_k, r_i, r_j, r_p, r_nm1;
  logic                    r_bad, r_zero, r_neg;
  logic                    r_done, r_singular, r_bad_out;
  logic [OUT_W-1:0]        r_result;

  logic signed [ACC_W-1:0] w_akk, w_aij, w_aik, w_akj, w_apk, w_last;
  logic signed [PW-1:0]    w_diff, w_quot;
  logic signed [ACC_W-1:0] w_new, w_det;
  logic [OUT_W-1:0]        w_red;
  logic [IDX_W-1:0]        w_kp1;
  logic                    w_pivot_nz, w_scan_nz, w_last_j, w_last_ij, w_k_last;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_LOAD;
      S_LOAD:   w_next = (r_bad || r_nm1 == '0) ? S_FINISH : S_PIVOT;
      S_PIVOT:  w_next = w_pivot_nz ? S_ELIM : S_SCAN;
      S_SCAN:   begin
        if (w_scan_nz)          w_next = S_SWAP;
        else if (r_p == r_nm1)  w_next = S_FINISH;
      end
      S_SWAP:   w_next = S_ELIM;
      S_ELIM:   if (w_last_ij) w_next = w_k_last ? S_FINISH : S_PIVOT;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output/datapath decode: element selection, Bareiss update, final reduction
  always_comb begin
    o_busy     = (r_state != S_IDLE);
    w_akk      = r_a[r_k][r_k];
    w_aij      = r_a[r_i][r_j];
    w_aik      = r_a[r_i][r_k];
    w_akj      = r_a[r_k][r_j];
    w_apk      = r_a[r_p][r_k];
    w_last     = r_a[r_nm1][r_nm1];
    w_kp1      = r_k + 1'b1;
    w_pivot_nz = (w_akk != '0);
    w_scan_nz  = (w_apk != '0);
    w_last_j   = (r_j == r_nm1);
    w_last_ij  = w_last_j && (r_i == r_nm1);
    w_k_last   = (w_kp1 == r_nm1);
    // Previous pivot always divides exactly, so truncating the quotient is lossless
    w_diff     = PW'(w_aij) * PW'(w_akk) - PW'(w_aik) * PW'(w_akj);
    w_quot     = w_diff / PW'(r_prev);
    w_new      = w_quot[ACC_W-1:0];
    w_det      = (r_bad || r_zero) ? '0 : (r_neg ? -w_last : w_last);
`ifdef MPU_DET_SAT_EN
    if (w_det > $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}}))
      w_red = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_det < $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}}))
      w_red = {1'b1, {(OUT_W-1){1'b0}}};
    else
      w_red = w_det[OUT_W-1:0];
`else
    w_red      = w_det[OUT_W-1:0];
`endif
  end

  // Working matrix, elimination indices and registered results
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int unsigned r = 0; r < MAX_N; r++)
        for (int unsigned c = 0; c < MAX_N; c++)
          r_a[r][c] <= '0;
      r_prev     <= {{(ACC_W-1){1'b0}}, 1'b1};
      r_k        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_p        <= '0;
      r_nm1      <= '0;
      r_bad      <= 1'b0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
      r_done     <= 1'b0;
      r_singular <= 1'b0;
      r_bad_out  <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= (r_state == S_FINISH);
      case (r_state)
        S_IDLE: begin
          // Operands are captured on the accepting edge; LOAD only routes
          if (i_start) begin
            for (int unsigned r = 0; r < MAX_N; r++)
              for (int unsigned c = 0; c < MAX_N; c++)
                r_a[r][c] <= {{(ACC_W-W){i_matrix[(r*MAX_N+c)*W+W-1]}},
                              i_matrix[(r*MAX_N+c)*W +: W]};
            r_nm1  <= IDX_W'(i_size - 4'd1);
            r_bad  <= (i_size == 4'd0) || (i_size > 4'(MAX_N));
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_prev <= {{(ACC_W-1){1'b0}}, 1'b1};
            r_k    <= '0;
          end
        end
        S_PIVOT: begin
          r_p <= w_kp1;
          r_i <= w_kp1;
          r_j <= w_kp1;
        end
        S_SCAN: begin
          if (!w_scan_nz) begin
            if (r_p == r_nm1) r_zero <= 1'b1;
            else              r_p    <= r_p + 1'b1;
          end
        end
        S_SWAP: begin
          for (int unsigned c = 0; c < MAX_N; c++) begin
            if (IDX_W'(c) >= r_k) begin
              r_a[r_k][c] <= r_a[r_p][c];
              r_a[r_p][c] <= r_a[r_k][c];
            end
          end
          r_neg <= ~r_neg;
        end
        S_ELIM: begin
          r_a[r_i][r_j] <= w_new;
          if (w_last_j) begin
            r_j <= w_kp1;
            if (w_last_ij) begin
              r_prev <= w_akk;
              r_k    <= w_kp1;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_FINISH: begin
          r_result   <= w_red;
          r_singular <= (w_det == '0);
          r_bad_out  <= r_bad;
        end
        default: ;
      endcase
    end
  end

  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_singular = r_singular;
  assign o_bad_size = r_bad_out;

endmodule
